// File: rtl/wxbar_elastic.sv
// Write-path crossbar stage: per-lane rotate (or lane-0 broadcast) feeding a
// LATENCY-deep bubble-collapsing valid/ready pipeline with sideband and conflict tracking.
module wxbar_elastic #(
  parameter  int NUM_COLS  = 32,
  parameter  int ELEM_BITS = 16,
  parameter  int LATENCY   = 2,
  parameter  int SRC_W     = 2,
  parameter  int SLOT_W    = 8,
  parameter  int CNT_W     = 16,
  localparam int IDX_W     = $clog2(NUM_COLS),
  localparam int DW        = NUM_COLS * ELEM_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_write,
  input  logic                      in_bcast,
  input  logic [SRC_W-1:0]          in_src,
  input  logic [SLOT_W-1:0]         in_slot_mask,
  input  logic [NUM_COLS-1:0]       in_valid_mask,
  input  logic [NUM_COLS*IDX_W-1:0] in_shift,
  input  logic [DW-1:0]             in_wdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SRC_W-1:0]          out_src,
  output logic [SLOT_W-1:0]         out_slot_mask,
  output logic [NUM_COLS-1:0]       out_valid_mask,
  output logic [DW-1:0]             out_wdata,
  output logic                      out_conflict,
  output logic [CNT_W-1:0]          conflict_cnt
);

  logic [DW-1:0]       perm_data;
  logic [NUM_COLS-1:0] perm_mask;
  logic                perm_conf;
  logic [IDX_W-1:0]    dest;

  // Ascending lane scan: the first valid lane to claim a destination wins,
  // any later claimant marks the beat as conflicting.
  always_comb begin
    perm_data = '0;
    perm_mask = '0;
    perm_conf = 1'b0;
    dest      = '0;
    if (in_bcast) begin
      for (int j = 0; j < NUM_COLS; j++)
        perm_data[j*ELEM_BITS +: ELEM_BITS] = in_wdata[ELEM_BITS-1:0];
      perm_mask = in_valid_mask;
    end else begin
      for (int i = 0; i < NUM_COLS; i++) begin
        if (in_valid_mask[i]) begin
          dest = IDX_W'(i) + in_shift[i*IDX_W +: IDX_W];
          if (perm_mask[dest]) begin
            perm_conf = 1'b1;
          end else begin
            perm_mask[dest] = 1'b1;
            perm_data[dest*ELEM_BITS +: ELEM_BITS] = in_wdata[i*ELEM_BITS +: ELEM_BITS];
          end
        end
      end
    end
  end

  logic [LATENCY-1:0]  st_v;
  logic [LATENCY-1:0]  st_conf;
  logic [LATENCY-1:0]  ld;
  logic                take;
  logic [DW-1:0]       st_data [LATENCY];
  logic [NUM_COLS-1:0] st_mask [LATENCY];
  logic [SRC_W-1:0]    st_src  [LATENCY];
  logic [SLOT_W-1:0]   st_slot [LATENCY];
  logic                load_beat;

  // A stage may load if it, or any stage downstream of it, frees up this cycle.
  always_comb begin
    ld   = '0;
    take = out_ready;
    for (int k = LATENCY - 1; k >= 0; k--) begin
      take  = take | ~st_v[k];
      ld[k] = take;
    end
  end

  assign in_ready  = ld[0] & ~flush;
  assign load_beat = in_valid & in_ready & in_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_v         <= '0;
      st_conf      <= '0;
      conflict_cnt <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        st_data[k] <= '0;
        st_mask[k] <= '0;
        st_src[k]  <= '0;
        st_slot[k] <= '0;
      end
    end else begin
      if (flush) begin
        st_v <= '0;
      end else begin
        if (ld[0]) st_v[0] <= load_beat;
        if (load_beat) begin
          st_data[0] <= perm_data;
          st_mask[0] <= perm_mask;
          st_src[0]  <= in_src;
          st_slot[0] <= in_slot_mask;
          st_conf[0] <= perm_conf;
        end
        for (int k = 1; k < LATENCY; k++) begin
          if (ld[k]) begin
            st_v[k] <= st_v[k-1];
            if (st_v[k-1]) begin
              st_data[k] <= st_data[k-1];
              st_mask[k] <= st_mask[k-1];
              st_src[k]  <= st_src[k-1];
              st_slot[k] <= st_slot[k-1];
              st_conf[k] <= st_conf[k-1];
            end
          end
        end
      end
      if (load_beat && perm_conf && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

  assign out_valid      = st_v[LATENCY-1];
  assign out_wdata      = st_data[LATENCY-1];
  assign out_valid_mask = st_mask[LATENCY-1];
  assign out_src        = st_src[LATENCY-1];
  assign out_slot_mask  = st_slot[LATENCY-1];
  assign out_conflict   = st_conf[LATENCY-1];

endmodule

// File: tb/tb_wxbar_elastic.sv
// Bench for wxbar_elastic: queue-of-beats reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_wxbar_elastic;
  localparam int NC  = 32;
  localparam int EB  = 16;
  localparam int LAT = 2;
  localparam int SW  = 2;
  localparam int SLW = 8;
  localparam int CW  = 16;
  localparam int IW  = $clog2(NC);
  localparam int DW  = NC * EB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            flush, in_valid, in_ready, in_write, in_bcast;
  logic [SW-1:0]   in_src;
  logic [SLW-1:0]  in_slot_mask;
  logic [NC-1:0]   in_valid_mask;
  logic [NC*IW-1:0] in_shift;
  logic [DW-1:0]   in_wdata;
  logic            out_valid, out_ready, out_conflict;
  logic [SW-1:0]   out_src;
  logic [SLW-1:0]  out_slot_mask;
  logic [NC-1:0]   out_valid_mask;
  logic [DW-1:0]   out_wdata;
  logic [CW-1:0]   conflict_cnt;

  wxbar_elastic #(.NUM_COLS(NC), .ELEM_BITS(EB), .LATENCY(LAT), .SRC_W(SW),
                  .SLOT_W(SLW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_write(in_write), .in_bcast(in_bcast), .in_src(in_src), .in_slot_mask(in_slot_mask),
    .in_valid_mask(in_valid_mask), .in_shift(in_shift), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
    .out_slot_mask(out_slot_mask), .out_valid_mask(out_valid_mask), .out_wdata(out_wdata),
    .out_conflict(out_conflict), .conflict_cnt(conflict_cnt)
  );

  typedef struct {
    logic [DW-1:0]  wdata;
    logic [NC-1:0]  vmask;
    logic [SW-1:0]  src;
    logic [SLW-1:0] slot;
    logic           conf;
    int             pos;
  } beat_t;

  beat_t q[$];
  int    np[$];
  int    m_cnt = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  logic  rec = 1'b0;
  logic  saw_stall = 1'b0;
  logic  last_in_ready;
  int    got[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Spec-level permutation: for each destination, search lanes for claimants.
  function automatic void m_perm(input logic bc, input logic [NC-1:0] vm,
                                 input logic [NC*IW-1:0] sh, input logic [DW-1:0] wd,
                                 output logic [DW-1:0] od, output logic [NC-1:0] om,
                                 output logic cf);
    od = '0; om = '0; cf = 1'b0;
    if (bc) begin
      for (int j = 0; j < NC; j++) od[j*EB +: EB] = wd[EB-1:0];
      om = vm;
    end else begin
      for (int j = 0; j < NC; j++) begin
        int hits;
        hits = 0;
        for (int i = 0; i < NC; i++) begin
          if (vm[i] && ((i + int'(sh[i*IW +: IW])) % NC) == j) begin
            if (hits == 0) begin
              od[j*EB +: EB] = wd[i*EB +: EB];
              om[j] = 1'b1;
            end
            hits++;
          end
        end
        if (hits >= 2) cf = 1'b1;
      end
    end
  endfunction

  // Beats advance one position unless the beat ahead still occupies the next one;
  // position LAT means the head left through the output.
  function automatic void m_plan();
    int prev, p, n;
    prev = LAT;
    np.delete();
    for (int idx = 0; idx < q.size(); idx++) begin
      p = q[idx].pos;
      if (idx == 0 && p == LAT - 1 && out_ready) n = LAT;
      else if (p + 1 <= LAT - 1 && p + 1 != prev) n = p + 1;
      else n = p;
      np.push_back(n);
      prev = n;
    end
  endfunction

  function automatic logic m_ready();
    m_plan();
    return !flush && (np.size() == 0 || np[np.size()-1] != 0);
  endfunction

  task automatic m_edge(input logic ir);
    beat_t b;
    if (flush) begin
      q.delete();
    end else begin
      m_plan();
      for (int idx = 0; idx < q.size(); idx++) q[idx].pos = np[idx];
      if (q.size() > 0 && q[0].pos == LAT) void'(q.pop_front());
    end
    if (in_valid && ir && in_write) begin
      m_perm(in_bcast, in_valid_mask, in_shift, in_wdata, b.wdata, b.vmask, b.conf);
      b.src = in_src; b.slot = in_slot_mask; b.pos = 0;
      q.push_back(b);
      if (b.conf && m_cnt < (2**CW - 1)) m_cnt++;
    end
  endtask

  task automatic check_outputs(input logic ir);
    logic mv;
    mv = (q.size() > 0) && (q[0].pos == LAT - 1);
    last_in_ready = in_ready;
    chk("in_ready", DW'(in_ready), DW'(ir));
    chk("out_valid", DW'(out_valid), DW'(mv));
    chk("conflict_cnt", DW'(conflict_cnt), DW'(m_cnt));
    if (mv) begin
      chk("out_wdata", out_wdata, q[0].wdata);
      chk("out_valid_mask", DW'(out_valid_mask), DW'(q[0].vmask));
      chk("out_src", DW'(out_src), DW'(q[0].src));
      chk("out_slot_mask", DW'(out_slot_mask), DW'(q[0].slot));
      chk("out_conflict", DW'(out_conflict), DW'(q[0].conf));
    end
    if (rec && out_valid && out_ready) got.push_back(int'(out_wdata[EB-1:0]));
    if (in_valid && !in_ready) saw_stall = 1'b1;
  endtask

  task automatic cycle(output logic acc);
    logic ir;
    @(negedge clk);
    ir = m_ready();
    check_outputs(ir);
    acc = in_valid && ir;
    @(posedge clk);
    m_edge(ir);
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    in_valid = 1'b0;
    repeat (n) cycle(a);
  endtask

  task automatic set_beat(input logic w, input logic b, input logic [NC-1:0] vm,
                          input logic [NC*IW-1:0] sh, input logic [DW-1:0] wd);
    in_valid = 1'b1; in_write = w; in_bcast = b;
    in_src = SW'($urandom); in_slot_mask = SLW'($urandom);
    in_valid_mask = vm; in_shift = sh; in_wdata = wd;
  endtask

  task automatic send(input logic w, input logic b, input logic [NC-1:0] vm,
                      input logic [NC*IW-1:0] sh, input logic [DW-1:0] wd);
    logic acc;
    int t;
    t = 0;
    set_beat(w, b, vm, sh, wd);
    do begin
      cycle(acc);
      t++;
    end while (!acc && t < 20);
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: got in_ready=0 for 20 cycles expected acceptance");
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0]    wd, exp;
    logic [NC*IW-1:0] sh;
    logic [NC-1:0]    vm;
    logic             acc;
    int               k;

    flush = 0; in_valid = 0; in_write = 0; in_bcast = 0; in_src = '0; in_slot_mask = '0;
    in_valid_mask = '0; in_shift = '0; in_wdata = '0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", DW'(out_valid), DW'(0));
    chk("reset_cnt", DW'(conflict_cnt), DW'(0));
    chk("reset_wdata", out_wdata, '0);
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1;
    chk("post_reset_in_ready", DW'(in_ready), DW'(1));

    // Conflict: lanes 3 and 5 both land on lane 7
    sh = '0; sh[3*IW +: IW] = IW'(4); sh[5*IW +: IW] = IW'(2);
    wd = '0; wd[3*EB +: EB] = 16'h3333; wd[5*EB +: EB] = 16'h5555;
    vm = 32'h0000_0028;
    send(1, 0, vm, sh, wd);
    idle(LAT - 1);
    chk("conf_valid", DW'(out_valid), DW'(1));
    chk("conf_lane7", DW'(out_wdata[7*EB +: EB]), DW'(16'h3333));
    chk("conf_mask", DW'(out_valid_mask), DW'(32'h0000_0080));
    chk("conf_flag", DW'(out_conflict), DW'(1));
    chk("conf_cnt", DW'(conflict_cnt), DW'(1));
    idle(2);
    send(1, 0, 32'h0000_0020, sh, wd);
    idle(LAT - 1);
    chk("noconf_lane7", DW'(out_wdata[7*EB +: EB]), DW'(16'h5555));
    chk("noconf_flag", DW'(out_conflict), DW'(0));
    chk("noconf_cnt", DW'(conflict_cnt), DW'(1));
    idle(2);

    // Identity
    for (int i = 0; i < NC; i++) wd[i*EB +: EB] = EB'(i);
    send(1, 0, '1, '0, wd);
    idle(LAT - 1);
    chk("ident_valid", DW'(out_valid), DW'(1));
    chk("ident_data", out_wdata, wd);
    chk("ident_mask", DW'(out_valid_mask), DW'(32'hFFFF_FFFF));
    chk("ident_conf", DW'(out_conflict), DW'(0));
    idle(2);

    // Rotate by one
    for (int i = 0; i < NC; i++) begin
      wd[i*EB +: EB] = EB'(16'h100 + i);
      sh[i*IW +: IW] = IW'(1);
      exp[((i + 1) % NC)*EB +: EB] = EB'(16'h100 + i);
    end
    send(1, 0, '1, sh, wd);
    idle(LAT - 1);
    chk("rot_data", out_wdata, exp);
    chk("rot_lane0_wrap", DW'(out_wdata[EB-1:0]), DW'(16'h011F));
    chk("rot_lane1", DW'(out_wdata[EB +: EB]), DW'(16'h0100));
    idle(2);

    // Broadcast
    wd = rand_data(); wd[EB-1:0] = 16'hABCD;
    send(1, 1, 32'h0000_00FF, rand_data(), wd);
    idle(LAT - 1);
    for (int j = 0; j < NC; j++) exp[j*EB +: EB] = 16'hABCD;
    chk("bcast_data", out_wdata, exp);
    chk("bcast_mask", DW'(out_valid_mask), DW'(32'h0000_00FF));
    chk("bcast_conf", DW'(out_conflict), DW'(0));
    idle(2);

    // Non-write beat carrying a would-be conflict
    wd = '0; wd[3*EB +: EB] = 16'h3333; wd[5*EB +: EB] = 16'h5555;
    sh = '0; sh[3*IW +: IW] = IW'(4); sh[5*IW +: IW] = IW'(2);
    send(0, 0, 32'h0000_0028, sh, wd);
    idle(LAT + 1);
    chk("nowrite_valid", DW'(out_valid), DW'(0));
    chk("nowrite_cnt", DW'(conflict_cnt), DW'(1));

    // Backpressure: 10 beats, out_ready low for 4 cycles
    rec = 1; got.delete(); saw_stall = 0; k = 0;
    for (int t = 0; t < 30; t++) begin
      if (k < 10) begin
        wd = rand_data(); wd[EB-1:0] = EB'(k);
        set_beat(1, 0, '1, '0, wd);
      end else in_valid = 0;
      out_ready = !(t >= 4 && t < 8);
      cycle(acc);
      if (acc) k++;
    end
    rec = 0; out_ready = 1; in_valid = 0;
    chk("bp_sent", DW'(k), DW'(10));
    chk("bp_stall_seen", DW'(saw_stall), DW'(1));
    chk("bp_count", DW'(got.size()), DW'(10));
    for (int i = 0; i < got.size() && i < 10; i++) chk("bp_order", DW'(got[i]), DW'(i));

    // Flush with two beats in flight
    send(1, 0, '1, '0, rand_data());
    send(1, 0, '1, '0, rand_data());
    set_beat(1, 0, '1, '0, rand_data());
    flush = 1; out_ready = 0;
    cycle(acc);
    chk("flush_in_ready", DW'(last_in_ready), DW'(0));
    flush = 0; in_valid = 0; out_ready = 1;
    chk("flush_out_valid", DW'(out_valid), DW'(0));
    idle(LAT + 1);
    chk("flush_drop", DW'(out_valid), DW'(0));

    // Randomised traffic
    for (int t = 0; t < 1500; t++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_write = ($urandom_range(0, 7) != 0);
      in_bcast = ($urandom_range(0, 7) == 0);
      in_src = SW'($urandom); in_slot_mask = SLW'($urandom);
      case ($urandom_range(0, 2))
        0: in_valid_mask = '1;
        1: in_valid_mask = $urandom;
        default: in_valid_mask = $urandom & $urandom & $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) in_shift = '0;
      else for (int i = 0; i < NC; i++) in_shift[i*IW +: IW] = IW'($urandom);
      in_wdata = rand_data();
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      cycle(acc);
    end
    flush = 0; out_ready = 1;
    idle(LAT + 2);

    // Reset asserted mid-stream
    wd = '0; wd[3*EB +: EB] = 16'h3333; wd[5*EB +: EB] = 16'h5555;
    set_beat(1, 0, 32'h0000_0028, sh, wd);
    cycle(acc);
    set_beat(1, 0, '1, '0, rand_data());
    cycle(acc);
    #2 rst = 1;
    #1;
    in_valid = 0;
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_wdata", out_wdata, '0);
    chk("rst_mask", DW'(out_valid_mask), DW'(0));
    chk("rst_conf", DW'(out_conflict), DW'(0));
    chk("rst_cnt", DW'(conflict_cnt), DW'(0));
    @(posedge clk);
    @(negedge clk) rst = 0;
    q.delete(); m_cnt = 0;
    @(posedge clk);
    #1;
    chk("after_rst_in_ready", DW'(in_ready), DW'(1));
    for (int i = 0; i < NC; i++) wd[i*EB +: EB] = EB'(i);
    send(1, 0, '1, '0, wd);
    idle(LAT - 1);
    chk("after_rst_valid", DW'(out_valid), DW'(1));
    chk("after_rst_lane5", DW'(out_wdata[5*EB +: EB]), DW'(5));
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
